// File: rtl/yadmc_wb_arbiter.sv
// Round-robin WISHBONE arbiter sharing the yadmc slave port between nmasters
// bus masters. A grant is held for the whole wb cycle (cyc high), so
// multi-access cycles are never split. The slave side is driven
// combinationally from the registered grant.
module yadmc_wb_arbiter #(
  parameter int unsigned nmasters = 4,
  parameter int unsigned ptr_w    = 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [32*nmasters-1:0]   m_adr_i,
  input  logic [32*nmasters-1:0]   m_dat_i,
  input  logic [4*nmasters-1:0]    m_sel_i,
  input  logic [nmasters-1:0]      m_we_i,
  input  logic [nmasters-1:0]      m_cyc_i,
  input  logic [nmasters-1:0]      m_stb_i,
  output logic [31:0]              m_dat_o,
  output logic [nmasters-1:0]      m_ack_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  input  logic [31:0]              s_dat_i,
  input  logic                     s_ack_i,
  output logic                     grant_valid,
  output logic [ptr_w-1:0]         grant_idx
);

  // Per-master vectors are padded out to the full pointer range so that any
  // ptr_w-bit index selects a defined (zero) bit.
  localparam int unsigned nslots = 32'd1 << ptr_w;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state;
  logic [ptr_w-1:0]   last_idx;
  logic [nslots-1:0]  cyc_ext;
  logic [nslots-1:0]  stb_ext;
  logic [nslots-1:0]  we_ext;
  logic [31:0]        adr_arr [nslots];
  logic [31:0]        dat_arr [nslots];
  logic [3:0]         sel_arr [nslots];
  logic [ptr_w-1:0]   drive_idx;
  logic [ptr_w-1:0]   scan_idx;
  logic [ptr_w-1:0]   cand_idx;
  logic               cand_found;
  logic               owner_cyc;

  assign cyc_ext = nslots'(m_cyc_i);
  assign stb_ext = nslots'(m_stb_i);
  assign we_ext  = nslots'(m_we_i);

  assign grant_valid = (state == OWNED);
  assign owner_cyc   = grant_valid & cyc_ext[grant_idx];

  // Unpack the flattened master buses into indexable per-master slices.
  always_comb begin
    for (int unsigned i = 0; i < nslots; i++) begin
      adr_arr[i] = '0;
      dat_arr[i] = '0;
      sel_arr[i] = '0;
    end
    for (int unsigned i = 0; i < nmasters; i++) begin
      adr_arr[i] = m_adr_i[32*i +: 32];
      dat_arr[i] = m_dat_i[32*i +: 32];
      sel_arr[i] = m_sel_i[4*i +: 4];
    end
  end

  // Round-robin scan starting after last_idx; the previous owner is checked last.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= nmasters; k++) begin
      scan_idx = ptr_w'((32'(last_idx) + k) % nmasters);
      if (!cand_found && cyc_ext[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // Grant state: re-arbitrate whenever nobody holds an active cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= ptr_w'(nmasters - 1);
    end else if (!owner_cyc) begin
      if (cand_found) begin
        state     <= OWNED;
        grant_idx <= cand_idx;
        last_idx  <= cand_idx;
      end else begin
        state     <= IDLE;
      end
    end
  end

  // Slave drive: owner's slice, or master 0's slice while idle.
  always_comb begin
    drive_idx = grant_valid ? grant_idx : '0;
    s_adr_o   = adr_arr[drive_idx];
    s_dat_o   = dat_arr[drive_idx];
    s_sel_o   = sel_arr[drive_idx];
    s_cyc_o   = owner_cyc;
    s_stb_o   = owner_cyc & stb_ext[grant_idx];
    s_we_o    = owner_cyc & we_ext[grant_idx];
  end

  // Ack routing: only the owner's active strobe sees the slave ack; a reset
  // cycle suppresses it so an aborted transfer never completes.
  always_comb begin
    m_ack_o = '0;
    m_dat_o = s_dat_i;
    for (int unsigned i = 0; i < nmasters; i++) begin
      m_ack_o[i] = s_ack_i & s_stb_o & ~sys_rst & (grant_idx == ptr_w'(i));
    end
  end

endmodule

// File: tb/tb_yadmc_wb_arbiter.sv
// Directed bench for yadmc_wb_arbiter with 4 masters.
module tb_yadmc_wb_arbiter;

  localparam int unsigned nm = 4;

  logic          sys_clk;
  logic          sys_rst;
  logic [127:0]  m_adr_i;
  logic [127:0]  m_dat_i;
  logic [15:0]   m_sel_i;
  logic [3:0]    m_we_i;
  logic [3:0]    m_cyc_i;
  logic [3:0]    m_stb_i;
  logic [31:0]   m_dat_o;
  logic [3:0]    m_ack_o;
  logic [31:0]   s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i;
  logic          grant_valid;
  logic [2:0]    grant_idx;

  int checks = 0;
  int errors = 0;

  yadmc_wb_arbiter #(.nmasters(nm), .ptr_w(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance to just after the next rising edge; inputs are then driven.
  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    for (int i = 0; i < 4; i++) begin
      m_adr_i[32*i +: 32] = 32'h1000_0000 + 32'(i);
      m_dat_i[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
    next_cycle();
    next_cycle();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_grant got valid=%b idx=%0d exp valid=0 idx=0", grant_valid, grant_idx);
    end
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0 || m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got cyc=%b stb=%b we=%b ack=%b exp all 0", s_cyc_o, s_stb_o, s_we_o, m_ack_o);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle_latency got s_cyc=%b exp 0", s_cyc_o);
    end
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(exp_seq[k]) || s_cyc_o !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant[%0d] got valid=%b idx=%0d cyc=%b exp valid=1 idx=%0d cyc=1",
                 k, grant_valid, grant_idx, s_cyc_o, exp_seq[k]);
      end
      checks++;
      if (m_ack_o !== 4'(1 << exp_seq[k])) begin
        errors++;
        $display("FAIL rr_ack[%0d] got %b exp %b", k, m_ack_o, 4'(1 << exp_seq[k]));
      end
      next_cycle();
      s_ack_i = 1'b0;
      m_cyc_i[exp_seq[k]] = 1'b0;
      #1;
      checks++;
      if (s_cyc_o !== 1'b0 || m_ack_o !== 4'b0000) begin
        errors++;
        $display("FAIL rr_handover_gap[%0d] got cyc=%b ack=%b exp cyc=0 ack=0000", k, s_cyc_o, m_ack_o);
      end
      next_cycle();
      m_cyc_i[exp_seq[k]] = 1'b1;
    end
  endtask

  task automatic test_hold_ownership();
    do_reset();
    m_cyc_i = 4'b0100;
    m_stb_i = 4'b0111;
    next_cycle();
    m_cyc_i = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (grant_idx !== 3'd2 || m_ack_o !== 4'b0100) begin
        errors++;
        $display("FAIL hold_ack[%0d] got idx=%0d ack=%b exp idx=2 ack=0100", k, grant_idx, m_ack_o);
      end
      next_cycle();
    end
    s_ack_i = 1'b0;
    m_cyc_i[2] = 1'b0;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0 || grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL hold_release got cyc=%b idx=%0d exp cyc=0 idx=2", s_cyc_o, grant_idx);
    end
    next_cycle();
    #1;
    checks++;
    if (grant_idx !== 3'd0 || s_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_owner got idx=%0d cyc=%b exp idx=0 cyc=1", grant_idx, s_cyc_o);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m_adr_i[63:32] = 32'h0000_1230;
    repeat (3) next_cycle();
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL read_latency_t got s_cyc=%b exp 0", s_cyc_o);
    end
    next_cycle();
    s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h0000_1230 || grant_idx !== 3'd1) begin
      errors++;
      $display("FAIL read_drive got cyc=%b stb=%b adr=%h idx=%0d exp cyc=1 stb=1 adr=00001230 idx=1",
               s_cyc_o, s_stb_o, s_adr_o, grant_idx);
    end
    checks++;
    if (m_dat_o !== 32'hDEAD_BEEF || m_ack_o !== 4'b0010) begin
      errors++;
      $display("FAIL read_data got dat=%h ack=%b exp dat=deadbeef ack=0010", m_dat_o, m_ack_o);
    end
    next_cycle();
    m_stb_i = 4'b0000;
    #1;
    checks++;
    if (s_stb_o !== 1'b0 || m_ack_o !== 4'b0000 || s_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL read_no_stb got stb=%b ack=%b cyc=%b exp stb=0 ack=0000 cyc=1", s_stb_o, m_ack_o, s_cyc_o);
    end
  endtask

  task automatic test_write_stall();
    int bad = 0;
    do_reset();
    m_adr_i[127:96] = 32'h0000_3000;
    m_dat_i[127:96] = 32'h0000_55AA;
    m_sel_i[15:12]  = 4'b0011;
    m_we_i          = 4'b1000;
    m_cyc_i         = 4'b1000;
    m_stb_i         = 4'b1011;
    next_cycle();
    m_cyc_i = 4'b1011;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (s_we_o !== 1'b1 || s_sel_o !== 4'b0011 || s_adr_o !== 32'h0000_3000 ||
          s_dat_o !== 32'h0000_55AA || grant_idx !== 3'd3 || m_ack_o !== 4'b0000) bad++;
      next_cycle();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_stable got %0d bad cycles exp 0", bad);
    end
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 4'b1000 || s_we_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_ack got ack=%b we=%b exp ack=1000 we=1", m_ack_o, s_we_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    next_cycle();
    m_cyc_i = 4'b1011;
    m_stb_i = 4'b1011;
    repeat (5) next_cycle();
    sys_rst = 1'b1;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL rst_cycle_ack got %b exp 0000", m_ack_o);
    end
    next_cycle();
    sys_rst = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || s_cyc_o !== 1'b0 || m_ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL rst_after got valid=%b cyc=%b ack=%b exp valid=0 cyc=0 ack=0000", grant_valid, s_cyc_o, m_ack_o);
    end
    s_ack_i = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_first_winner got valid=%b idx=%0d exp valid=1 idx=0", grant_valid, grant_idx);
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    s_ack_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (m_ack_o !== 4'b0000 || grant_valid !== 1'b0 || m_dat_o !== 32'h1234_5678) begin
        errors++;
        $display("FAIL spurious_ack[%0d] got ack=%b valid=%b dat=%h exp ack=0000 valid=0 dat=12345678",
                 k, m_ack_o, grant_valid, m_dat_o);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold_ownership();
    test_single_read();
    test_write_stall();
    test_reset_mid_stall();
    test_spurious_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
